regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file with registered reads, an optional write-to-read bypass and a per-register busy scoreboard. It is the next generation of the core's architectural register storage: the issue stage claims destination registers, the writeback stage retires results, and operand fetch reads values together with their busy state. It replaces the fixed 32x32, two-port, tri-state variant with separate unidirectional read and write ports.

## Interface
- DATA_W, 64, register width in bits
- NUM_REGS, 32, number of registers (power of two, 2..256)
- ADDR_W, $clog2(NUM_REGS), register select width
- RD_PORTS, 2, read ports (1..4)
- WR_PORTS, 2, write ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes and claims

- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_rd_en  in  RD_PORTS  per-port read request
- i_rd_sel  in  RD_PORTS x ADDR_W  per-port read select
- o_rd_data  out  RD_PORTS x DATA_W  registered read data
- o_rd_valid  out  RD_PORTS  high one cycle after the matching i_rd_en
- o_rd_busy  out  RD_PORTS  registered busy state of the selected register
- i_wr_en  in  WR_PORTS  per-port write enable
- i_wr_sel  in  WR_PORTS x ADDR_W  per-port write select
- i_wr_data  in  WR_PORTS x DATA_W  per-port write data
- i_claim_en  in  1  mark a register busy (pending producer)
- i_claim_sel  in  ADDR_W  register to claim
- o_busy  out  NUM_REGS  live scoreboard vector

## Operation
- Reset: all registers 0, all busy bits 0, o_rd_data 0, o_rd_valid 0, o_rd_busy 0. Reset asserted mid-operation discards in-flight reads; no o_rd_valid while i_rst is high or on the first edge after release unless i_rd_en is sampled then.
- Write: on a clock edge with i_wr_en[w], the register at i_wr_sel[w] takes i_wr_data[w] and its busy bit clears.
- Write conflict: several ports on the same register in one cycle, the highest-index port wins.
- Claim: i_claim_en sets busy[i_claim_sel]. Claim and write to the same register in one cycle leaves busy set, because the claim is a newer producer. The write data is still stored.
- Read: on an edge with i_rd_en[p], o_rd_data[p] and o_rd_busy[p] load from i_rd_sel[p] and o_rd_valid[p] goes high. Without i_rd_en[p], o_rd_data[p] and o_rd_busy[p] hold and o_rd_valid[p] goes low.
- ZERO_REG=1: register 0 writes and claims are dropped, and reads of register 0 return 0 with busy 0.
- Selects at or above NUM_REGS cannot occur for power-of-two depth. No range checking.

## Timing
- Read latency is 1 cycle: data sampled at edge N is visible after edge N.
- Write is visible to a read issued on the next cycle.
- Same-cycle read and write to the same register: behaviour is set by the bypass macro (see Configuration).
- o_busy changes on the edge after the claim or write.
- Throughput: every port can be used every cycle, with no stalls.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read that is same-cycle with a write to the same register returns the new data, using the highest-index write port.
  - o_rd_busy returns the post-edge busy state: 0 unless a claim also targets that register.
- REGFILE_BYPASS_EN undefined:
  - The same-cycle read returns the old stored value and the pre-edge busy bit.
  - This removes the write-data mux from the read path.

## Structure
- Package regfile_pkg holds:
  - default parameter constants (REGFILE_DATA_W, REGFILE_NUM_REGS)
  - typedef reg_num_t for a 5-bit register select, replacing the old enum
  - a function giving the winning write port for a select
- Sub-module regfile_scoreboard holds the busy-bit vector, claim/clear priority and ZERO_REG masking. Its ports are i_clk, i_rst, claim, clear vector and o_busy.
- The top level holds storage, write arbitration, read registers and bypass muxes.

## Test plan
- Reset: write 0xDEAD to R5, assert i_rst mid-cycle, read R5 -> o_rd_data 0, o_rd_busy 0, o_busy all 0.
- Basic write then read: write 0x1234 to R3 on port 0; next cycle read R3 on port 1 -> o_rd_data[1]=0x1234 one cycle later, o_rd_valid[1]=1.
- Write conflict: port 0 writes 0xAAAA and port 1 writes 0xBBBB to R7 in the same cycle; then read R7 -> 0xBBBB.
- Scoreboard:
  - Claim R9 -> o_busy[9]=1.
  - Write R9 together with a new claim of R9 -> o_busy[9] stays 1.
  - Write R9 alone -> o_busy[9]=0.
- Zero register (ZERO_REG=1): write 0xFFFF and claim R0, then read R0 -> data 0, busy 0, o_busy[0]=0.
- Bypass: R4 holds 0x11; read R4 in the same cycle as a write of 0x22 -> 0x22 with REGFILE_BYPASS_EN, 0x11 without it.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults, register-select type and write-port priority helper for the register file.
package regfile_pkg;

  localparam int REGFILE_DATA_W   = 64;
  localparam int REGFILE_NUM_REGS = 32;

  typedef logic [4:0] reg_num_t;

  // Winning write port among those hitting one select: highest index, -1 when none.
  function automatic int win_port(input logic [3:0] hits);
    win_port = -1;
    for (int w = 0; w < 4; w++) begin
      if (hits[w]) win_port = w;
    end
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: claim sets, write clears, claim beats a same-cycle clear.
// Updates on the edge after claim/clear; register 0 never busy when ZERO_REG=1; never stalls.
module regfile_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_claim_en,
  input  logic [ADDR_W-1:0]   i_claim_sel,
  input  logic [NUM_REGS-1:0] i_clear,
  output logic [NUM_REGS-1:0] o_busy
);

  logic [NUM_REGS-1:0] busy_nxt;

  always_comb begin
    busy_nxt = o_busy & ~i_clear;
    if (i_claim_en) busy_nxt[i_claim_sel] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_busy <= '0;
    else       o_busy <= busy_nxt;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard; reads registered (1 cycle), every port usable each cycle, no stalls.
// REGFILE_BYPASS_EN: same-cycle write data and post-edge busy forwarded to reads; otherwise reads see pre-edge state.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int NUM_REGS = REGFILE_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [RD_PORTS-1:0]              i_rd_en,
  input  logic [RD_PORTS-1:0][ADDR_W-1:0]  i_rd_sel,
  output logic [RD_PORTS-1:0][DATA_W-1:0]  o_rd_data,
  output logic [RD_PORTS-1:0]              o_rd_valid,
  output logic [RD_PORTS-1:0]              o_rd_busy,
  input  logic [WR_PORTS-1:0]              i_wr_en,
  input  logic [WR_PORTS-1:0][ADDR_W-1:0]  i_wr_sel,
  input  logic [WR_PORTS-1:0][DATA_W-1:0]  i_wr_data,
  input  logic                             i_claim_en,
  input  logic [ADDR_W-1:0]                i_claim_sel,
  output logic [NUM_REGS-1:0]              o_busy
);

  logic [DATA_W-1:0]                mem     [NUM_REGS];
  logic [DATA_W-1:0]                wr_val  [NUM_REGS];
  logic [3:0]                       wr_hits [NUM_REGS];
  logic [NUM_REGS-1:0]              clr;
  logic [RD_PORTS-1:0][DATA_W-1:0]  rd_data_nxt;
  logic [RD_PORTS-1:0]              rd_busy_nxt;

  // Per-register write decode; clr doubles as the storage write strobe.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      wr_hits[r] = '0;
      wr_val[r]  = '0;
      for (int w = 0; w < WR_PORTS; w++) begin
        if (i_wr_en[w] && i_wr_sel[w] == ADDR_W'(r)) wr_hits[r][w] = 1'b1;
      end
      for (int w = 0; w < WR_PORTS; w++) begin
        if (w == win_port(wr_hits[r])) wr_val[r] = i_wr_data[w];
      end
      clr[r] = |wr_hits[r] && !(ZERO_REG != 0 && r == 0);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (clr[r]) mem[r] <= wr_val[r];
      end
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_claim_en  (i_claim_en),
    .i_claim_sel (i_claim_sel),
    .i_clear     (clr),
    .o_busy      (o_busy)
  );

  always_comb begin
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_data_nxt[p] = mem[i_rd_sel[p]];
      rd_busy_nxt[p] = o_busy[i_rd_sel[p]];
`ifdef REGFILE_BYPASS_EN
      if (clr[i_rd_sel[p]]) begin
        rd_data_nxt[p] = wr_val[i_rd_sel[p]];
        rd_busy_nxt[p] = 1'b0;
      end
      // A same-cycle claim is the newer producer, so the register reads back busy.
      if (i_claim_en && i_claim_sel == i_rd_sel[p] &&
          !(ZERO_REG != 0 && i_rd_sel[p] == '0)) begin
        rd_busy_nxt[p] = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rd_data  <= '0;
      o_rd_valid <= '0;
      o_rd_busy  <= '0;
    end else begin
      o_rd_valid <= i_rd_en;
      for (int p = 0; p < RD_PORTS; p++) begin
        if (i_rd_en[p]) begin
          o_rd_data[p] <= rd_data_nxt[p];
          o_rd_busy[p] <= rd_busy_nxt[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp against an array-based model of register and busy state.
module tb_regfile_mp;

  logic             clk;
  logic             rst;
  logic [1:0]       rd_en;
  logic [1:0][4:0]  rd_sel;
  logic [1:0][63:0] rd_data;
  logic [1:0]       rd_valid;
  logic [1:0]       rd_busy;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_sel;
  logic [1:0][63:0] wr_data;
  logic             claim_en;
  logic [4:0]       claim_sel;
  logic [31:0]      busy;

  logic [63:0] m_mem [32];
  logic [31:0] m_busy;
  logic [63:0] e_data  [2];
  logic        e_busy  [2];
  logic        e_valid [2];

  int n_vec = 0;
  int n_err = 0;

  regfile_mp dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rd_en     (rd_en),
    .i_rd_sel    (rd_sel),
    .o_rd_data   (rd_data),
    .o_rd_valid  (rd_valid),
    .o_rd_busy   (rd_busy),
    .i_wr_en     (wr_en),
    .i_wr_sel    (wr_sel),
    .i_wr_data   (wr_data),
    .i_claim_en  (claim_en),
    .i_claim_sel (claim_sel),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    rd_en = '0; rd_sel = '0; wr_en = '0; wr_sel = '0; wr_data = '0;
    claim_en = 1'b0; claim_sel = '0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_mem[r] = '0;
    m_busy = '0;
    for (int p = 0; p < 2; p++) begin
      e_data[p] = '0; e_busy[p] = 1'b0; e_valid[p] = 1'b0;
    end
  endtask

  // One clock with the currently driven inputs; checks every output after the edge.
  task automatic step();
    logic [63:0] nmem [32];
    logic [31:0] nbusy;
    nmem  = m_mem;
    nbusy = m_busy;
    for (int w = 0; w < 2; w++) begin
      if (wr_en[w] && wr_sel[w] != 5'd0) begin
        nmem[wr_sel[w]]  = wr_data[w];
        nbusy[wr_sel[w]] = 1'b0;
      end
    end
    if (claim_en && claim_sel != 5'd0) nbusy[claim_sel] = 1'b1;
    for (int p = 0; p < 2; p++) begin
      e_valid[p] = rd_en[p];
      if (rd_en[p]) begin
`ifdef REGFILE_BYPASS_EN
        e_data[p] = nmem[rd_sel[p]];
        e_busy[p] = nbusy[rd_sel[p]];
`else
        e_data[p] = m_mem[rd_sel[p]];
        e_busy[p] = m_busy[rd_sel[p]];
`endif
      end
    end
    @(posedge clk);
    #1;
    m_mem  = nmem;
    m_busy = nbusy;
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rd_data[%0d]", p),  rd_data[p],  e_data[p]);
      chk($sformatf("rd_valid[%0d]", p), rd_valid[p], e_valid[p]);
      chk($sformatf("rd_busy[%0d]", p),  rd_busy[p],  e_busy[p]);
    end
    chk("o_busy", busy, m_busy);
  endtask

  // Reset asserted between clock edges; outputs must clear without an edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    #1;
    model_reset();
    chk("rst_rd_data0", rd_data[0], 64'h0);
    chk("rst_rd_data1", rd_data[1], 64'h0);
    chk("rst_rd_valid", rd_valid, 64'h0);
    chk("rst_rd_busy", rd_busy, 64'h0);
    chk("rst_o_busy", busy, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    #7;
    chk("por_rd_data0", rd_data[0], 64'h0);
    chk("por_rd_valid", rd_valid, 64'h0);
    chk("por_o_busy", busy, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step();

    // Reset discards stored data
    idle(); wr_en[0] = 1'b1; wr_sel[0] = 5'd5; wr_data[0] = 64'hDEAD;
    claim_en = 1'b1; claim_sel = 5'd6;
    step();
    do_reset();
    idle(); rd_en[0] = 1'b1; rd_sel[0] = 5'd5;
    step();
    chk("reset_r5_data", rd_data[0], 64'h0);
    chk("reset_r5_busy", rd_busy[0], 64'h0);

    // Basic write then read on the other port
    idle(); wr_en[0] = 1'b1; wr_sel[0] = 5'd3; wr_data[0] = 64'h1234;
    step();
    idle(); rd_en[1] = 1'b1; rd_sel[1] = 5'd3;
    step();
    chk("basic_data", rd_data[1], 64'h1234);
    chk("basic_valid", rd_valid[1], 64'h1);

    // Write conflict: higher port wins
    idle();
    wr_en = 2'b11; wr_sel[0] = 5'd7; wr_sel[1] = 5'd7;
    wr_data[0] = 64'hAAAA; wr_data[1] = 64'hBBBB;
    step();
    idle(); rd_en[0] = 1'b1; rd_sel[0] = 5'd7;
    step();
    chk("conflict_data", rd_data[0], 64'hBBBB);

    // Scoreboard claim / write+claim / write
    idle(); claim_en = 1'b1; claim_sel = 5'd9;
    step();
    chk("claim_busy9", busy[9], 64'h1);
    idle(); claim_en = 1'b1; claim_sel = 5'd9;
    wr_en[1] = 1'b1; wr_sel[1] = 5'd9; wr_data[1] = 64'h99;
    step();
    chk("wr_claim_busy9", busy[9], 64'h1);
    idle(); wr_en[0] = 1'b1; wr_sel[0] = 5'd9; wr_data[0] = 64'h98;
    step();
    chk("wr_busy9", busy[9], 64'h0);

    // Zero register ignores writes and claims
    idle(); wr_en[0] = 1'b1; wr_sel[0] = 5'd0; wr_data[0] = 64'hFFFF;
    claim_en = 1'b1; claim_sel = 5'd0;
    step();
    idle(); rd_en = 2'b11; rd_sel[0] = 5'd0; rd_sel[1] = 5'd0;
    step();
    chk("zero_data", rd_data[0], 64'h0);
    chk("zero_busy", rd_busy[1], 64'h0);
    chk("zero_o_busy0", busy[0], 64'h0);

    // Same-cycle read and write of R4
    idle(); wr_en[0] = 1'b1; wr_sel[0] = 5'd4; wr_data[0] = 64'h11;
    step();
    idle(); wr_en[1] = 1'b1; wr_sel[1] = 5'd4; wr_data[1] = 64'h22;
    rd_en[0] = 1'b1; rd_sel[0] = 5'd4;
    step();
`ifdef REGFILE_BYPASS_EN
    chk("bypass_data", rd_data[0], 64'h22);
`else
    chk("bypass_data", rd_data[0], 64'h11);
`endif

    // Randomized traffic, selects biased toward a few registers to force collisions
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      idle();
      rd_en    = 2'($urandom);
      wr_en    = 2'($urandom);
      claim_en = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < 2; k++) begin
        rd_sel[k]  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        wr_sel[k]  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        wr_data[k] = {$urandom, $urandom};
      end
      claim_sel = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
